// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, states,
// ALU control codes and datapath select encodings.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
   } state_t;

   typedef enum logic [1:0] {AM_ADD, AM_SUB, AM_FR, AM_FI} alu_mode_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control decoder: fixed add/sub or funct-driven
// selection for R-type and I-type, flagging unsupported funct codes.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_mode_t   mode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   output logic [2:0]  alu_control,
   output logic        funct_illegal
);

   always_comb begin
      alu_control   = ALU_ADD;
      funct_illegal = 1'b0;
      case (mode)
         AM_ADD: alu_control = ALU_ADD;
         AM_SUB: alu_control = ALU_SUB;
         AM_FR: begin
            case ({funct7_5, funct3})
               4'b0000: alu_control = ALU_ADD;
               4'b1000: alu_control = ALU_SUB;
               4'b0111: alu_control = ALU_AND;
               4'b0110: alu_control = ALU_OR;
               4'b0010: alu_control = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         AM_FI: begin
            // Immediate forms have no sub, so funct7_5 carries no meaning here.
            case (funct3)
               3'b000:  alu_control = ALU_ADD;
               3'b111:  alu_control = ALU_AND;
               3'b110:  alu_control = ALU_OR;
               3'b010:  alu_control = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle control FSM sequencing a shared-ALU, shared-memory
// datapath through fetch/decode/execute/memory/writeback, with illegal trapping.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE   = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       illegal
);

   state_t    state_q, state_d;
   logic      illegal_q, illegal_d;
   alu_mode_t alu_mode;
   logic      funct_illegal;
   logic      ready;
   logic      pc_write, mem_write, ir_write, reg_write, done;
   state_t    ill_next;

   assign ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign ill_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

   alu_decoder u_alu_decoder (
      .mode          (alu_mode),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .alu_control   (ALUControl),
      .funct_illegal (funct_illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      alu_mode  = AM_ADD;
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      case (state_q)
         S_FETCH: begin
            ResultSrc = RES_ALU;
            ALUSrcB   = SRCB_FOUR;
            if (ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : ill_next;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = ill_next;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEM;
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            if (ready) begin
               done    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA  = SRCA_RS1;
            alu_mode = AM_FR;
            state_d  = funct_illegal ? ill_next : S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            alu_mode = AM_FI;
            state_d  = funct_illegal ? ill_next : S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA  = SRCA_RS1;
            alu_mode = AM_SUB;
            pc_write = funct3[0] ? ~zero : zero;
            done     = 1'b1;
            state_d  = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            pc_write = 1'b1;
            state_d  = S_ALUWB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
      if (state_d == S_TRAP) illegal_d = 1'b1;
   end

   // Strobes are masked while reset is high so nothing is written during or after an abort.
   assign PCWrite    = pc_write  & ~reset;
   assign MemWrite   = mem_write & ~reset;
   assign IRWrite    = ir_write  & ~reset;
   assign RegWrite   = reg_write & ~reset;
   assign instr_done = done      & ~reset;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors
// are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q[$];
   string       tag_q[$];

   multicycle_control #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,instr_done,illegal}
   function automatic logic [15:0] ov(bit pcw, bit adr, bit mw, bit irw, bit rw,
                                      logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                      logic [2:0] ac, bit dn, bit ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, dn, ill};
   endfunction

   logic [15:0] obs_vec;
   assign obs_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, instr_done, illegal};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         string       t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, {16'h0, obs_vec}, {16'h0, e});
      end
   end

   localparam logic [15:0] F_RDY  = 16'b1_0_0_1_0_10_00_10_000_0_0;
   localparam logic [15:0] F_IDLE = 16'b0_0_0_0_0_10_00_10_000_0_0;
   localparam logic [15:0] DEC    = 16'b0_0_0_0_0_00_01_01_000_0_0;
   localparam logic [15:0] MADR   = 16'b0_0_0_0_0_00_10_01_000_0_0;
   localparam logic [15:0] MRD    = 16'b0_1_0_0_0_00_00_00_000_0_0;
   localparam logic [15:0] MWB    = 16'b0_0_0_0_1_01_00_00_000_1_0;
   localparam logic [15:0] AWB    = 16'b0_0_0_0_1_00_00_00_000_1_0;
   localparam logic [15:0] JALV   = 16'b1_0_0_0_0_00_01_10_000_0_0;
   localparam logic [15:0] TRAPV  = 16'b0_0_0_0_0_00_00_00_000_0_1;

   // Drive one cycle of inputs, queue the expected outputs, advance to just after the next edge.
   task automatic step(input bit rdy, input bit z, input logic [15:0] exp, input string tag);
      mem_ready = rdy;
      zero      = z;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f7;
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
      set_ir(7'b0000000, 3'b000, 1'b0);
      @(posedge clk); #1;
      step(1, 0, F_IDLE, "reset_hold0");
      step(1, 0, F_IDLE, "reset_hold1");
      reset = 1'b0;

      // lw with two wait cycles in MEMREAD, one wait in FETCH first
      set_ir(7'b0000011, 3'b010, 1'b0);
      step(0, 0, F_IDLE, "lw_fetch_wait");
      step(1, 0, F_RDY,  "lw_fetch");
      step(0, 0, DEC,    "lw_decode");
      step(1, 0, MADR,   "lw_memadr");
      step(0, 0, MRD,    "lw_memread_w1");
      step(0, 0, MRD,    "lw_memread_w2");
      step(1, 0, MRD,    "lw_memread");
      step(1, 0, MWB,    "lw_memwb");

      // R-type sub then slt
      set_ir(7'b0110011, 3'b000, 1'b1);
      step(1, 0, F_RDY, "sub_fetch");
      step(1, 0, DEC,   "sub_decode");
      step(1, 0, ov(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0), "sub_execr");
      step(1, 0, AWB,   "sub_aluwb");
      set_ir(7'b0110011, 3'b010, 1'b0);
      step(1, 0, F_RDY, "slt_fetch");
      step(1, 0, DEC,   "slt_decode");
      step(1, 0, ov(0,0,0,0,0,2'b00,2'b10,2'b00,3'b101,0,0), "slt_execr");
      step(1, 0, AWB,   "slt_aluwb");

      // andi with funct7_5 set (ignored)
      set_ir(7'b0010011, 3'b111, 1'b1);
      step(1, 0, F_RDY, "andi_fetch");
      step(1, 0, DEC,   "andi_decode");
      step(1, 0, ov(0,0,0,0,0,2'b00,2'b10,2'b01,3'b010,0,0), "andi_execi");
      step(1, 0, AWB,   "andi_aluwb");

      // beq taken, bne not taken, both with zero=1
      set_ir(7'b1100011, 3'b000, 1'b0);
      step(1, 1, F_RDY, "beq_fetch");
      step(1, 1, DEC,   "beq_decode");
      step(1, 1, ov(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0), "beq_branch");
      set_ir(7'b1100011, 3'b001, 1'b0);
      step(1, 1, F_RDY, "bne_fetch");
      step(1, 1, DEC,   "bne_decode");
      step(1, 1, ov(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0), "bne_branch");
      set_ir(7'b1100011, 3'b001, 1'b0);
      step(1, 0, F_RDY, "bne2_fetch");
      step(1, 0, DEC,   "bne2_decode");
      step(1, 0, ov(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0), "bne2_branch");

      // jal
      set_ir(7'b1101111, 3'b000, 1'b0);
      step(1, 0, F_RDY, "jal_fetch");
      step(0, 0, DEC,   "jal_decode");
      step(0, 0, JALV,  "jal_jal");
      step(1, 0, AWB,   "jal_aluwb");

      // sw aborted by asynchronous reset during a MEMWRITE wait
      set_ir(7'b0100011, 3'b010, 1'b0);
      step(1, 0, F_RDY, "sw_fetch");
      step(1, 0, DEC,   "sw_decode");
      step(1, 0, MADR,  "sw_memadr");
      step(0, 0, ov(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0), "sw_memwrite_w1");
      mem_ready = 1'b0;
      chk("sw_mw_before_abort", {31'h0, MemWrite}, 32'd1);
      reset = 1'b1;
      #1;
      chk("sw_mw_abort", {31'h0, MemWrite}, 32'd0);
      chk("sw_adr_abort", {31'h0, AdrSrc}, 32'd0);
      step(1, 0, F_IDLE, "sw_reset_hold");
      reset = 1'b0;
      step(1, 0, F_RDY, "sw_after_fetch");
      step(1, 0, DEC,   "sw2_decode");
      step(1, 0, MADR,  "sw2_memadr");
      step(1, 0, ov(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,1,0), "sw2_memwrite");

      // illegal opcode: trap holds with no strobes for 20 cycles
      set_ir(7'b1111111, 3'b000, 1'b0);
      step(1, 0, F_RDY, "ill_fetch");
      step(1, 0, DEC,   "ill_decode");
      for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TRAPV, "ill_trap");
      reset = 1'b1;
      step(1, 0, F_IDLE, "trap_reset");
      reset = 1'b0;
      chk("trap_cleared", {31'h0, illegal}, 32'd0);

      // branch with unsupported funct3 also traps
      set_ir(7'b1100011, 3'b010, 1'b0);
      step(1, 0, F_RDY, "brill_fetch");
      step(1, 0, DEC,   "brill_decode");
      step(1, 0, TRAPV, "brill_trap");
      step(1, 0, TRAPV, "brill_trap2");
      reset = 1'b1;
      step(1, 0, F_IDLE, "brill_reset");
      reset = 1'b0;
      step(1, 0, F_RDY, "post_reset_fetch");

      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle control decoder. It is a Moore-style FSM that sequences the shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps. It adds slt/slti/andi/ori, bne and jal decode, a 3-bit ALU control, an optional memory-ready handshake and illegal-instruction trapping. It sits beside the datapath and drives every mux select and write strobe.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait on `mem_ready`; 0 = memory always completes in one cycle (`mem_ready` ignored).
- `TRAP_ON_ILLEGAL`, default 1: 1 = illegal opcode or funct goes to TRAP; 0 = instruction is dropped and the FSM returns to FETCH.
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `opcode` input 7: from the instruction register.
- `funct3` input 3: from the instruction register.
- `funct7_5` input 1: from the instruction register.
- `zero` input 1: ALU result == 0.
- `mem_ready` input 1: memory access completes this cycle.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: instruction register / OldPC enable.
- `RegWrite` output 1: register file write.
- `ResultSrc` output 2: result select. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ALUSrcA` output 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` output 2: ALU B select. 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUControl` output 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` output 1: one-cycle pulse in the final state of each instruction.
- `illegal` output 1: sticky trap flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - When ready (`mem_ready`, or always if `MEM_HANDSHAKE`=0): IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise hold FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (computes branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011: MEMADR.
  - 0110011: EXECR.
  - 0010011: EXECI.
  - 1100011 with funct3 000 or 001: BRANCH.
  - 1101111: JAL.
  - Anything else: illegal.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1. Hold until ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, `instr_done`. Go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held through wait cycles. Pulse `instr_done` and go to FETCH on ready.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALUControl from {funct7_5,funct3}:
  - 0000 add, 1000 sub, 0111 and, 0110 or, 0010 slt.
  - Other codes are illegal.
  - Legal codes go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. ALUControl from funct3 (funct7_5 ignored):
  - 000 add, 111 and, 110 or, 010 slt.
  - Other codes are illegal.
  - Legal codes go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, `instr_done`. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = `zero` for beq, `!zero` for bne.
  - `instr_done`; go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB (writes OldPC+4 to rd).
- Illegal handling:
  - `TRAP_ON_ILLEGAL`=1: go to TRAP. TRAP sets `illegal`=1 and holds; all strobes are 0; only `reset` exits.
  - `TRAP_ON_ILLEGAL`=0: go to FETCH with no writes and no `instr_done`.
- No datapath write is ever issued for an illegal instruction.

## Timing
- Reset: state=FETCH, `illegal`=0. While `reset` is high, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, `instr_done`) are forced to 0 and the selects hold their FETCH values.
- Reset asserted mid-instruction aborts it immediately (asynchronous). No partial write occurs after assertion.
- Outputs are combinational from state. Exceptions: PCWrite/IRWrite (FETCH), MemWrite completion and next-state also depend on `mem_ready` and `zero` in the same cycle.
- Cycles with zero wait: beq/bne 3, R-type/I-type/sw/jal 4, lw 5.
- Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- `mem_ready` outside memory states is ignored.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - state enum;
  - ALUControl codes;
  - ResultSrc/ALUSrcA/ALUSrcB encodings.
- Sub-module `alu_decoder`: combinational. Inputs: mode (add / sub / funct-R / funct-I), funct3, funct7_5. Outputs: ALUControl and a funct_illegal flag. Instantiated once.

## Test plan
- lw with `mem_ready` low 2 cycles in MEMREAD → states FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB. RegWrite=1 with ResultSrc=01 only in cycle 7; `instr_done` once.
- R-type {funct7_5,funct3}=1000 then 0010 → ALUControl 001 then 101 in EXECR; RegWrite in ALUWB; 4 cycles each.
- beq with zero=1, then bne with zero=1 → PCWrite=1 in BRANCH for beq; PCWrite=0 for bne; both 3 cycles.
- jal → PCWrite=1 in JAL with ALUSrcA=01, ALUSrcB=10; RegWrite=1 with ResultSrc=00 next cycle.
- opcode 1111111, `TRAP_ON_ILLEGAL`=1 → TRAP after DECODE, `illegal`=1, no strobes for 20 cycles. `reset` pulse → FETCH, `illegal`=0.
- sw with `reset` asserted during MEMWRITE wait → MemWrite drops asynchronously; state=FETCH after release.
